ikbd_serial_tx: RTL and testbench

Byte-to-line serializer that generates the 8N1 serial stream arriving on the ACIA `rx` input. It sits directly upstream of the ACIA receiver. The io controller pushes keyboard/MIDI bytes (received over SPI) into it, and it emits them at ST iKBD or MIDI bit rates with exact bit timing on the 32 MHz system clock. It buffers bytes so bursts from the io controller are never lost while a frame is on the line.

---
 rtl/ikbd_serial_tx.sv | 173 +++++++++++++++++
 tb/tb_ikbd_serial_tx.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ikbd_serial_tx.sv
// 8N1 serializer feeding the ACIA rx line at iKBD or MIDI bit rates.
// Define IKBD_SERIAL_TX_FIFO_EN for a 2^DEPTH_LOG2 FIFO; otherwise a single holding register.
module ikbd_serial_tx #(
    parameter int DIV_SLOW   = 4096,
    parameter int DIV_FAST   = 1024,
    parameter int DEPTH_LOG2 = 4,
    parameter int GAP_BITS   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            din,
    input  logic                  strobe,
    input  logic                  fast,
    output logic                  tx,
    output logic                  busy,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [11:0] RELOAD_SLOW = 12'(DIV_SLOW - 1);
    localparam logic [11:0] RELOAD_FAST = 12'(DIV_FAST - 1);
    localparam logic [3:0]  GAP_LAST = 4'(GAP_BITS > 0 ? GAP_BITS - 1 : 0);
    localparam bit          HAS_GAP = GAP_BITS > 0;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

    state_t      state;
    logic [11:0] timer;
    logic [7:0]  shift;
    logic [2:0]  idx;
    logic [3:0]  gap_cnt;
    logic        fast_q;

    logic [7:0]  head;
    logic        empty;
    logic        tick;
    logic        frame_end;
    logic        pop;
    logic        write;

    assign tick = timer == 12'd0;
    // Popping on the last line clock keeps back-to-back frames seamless.
    assign frame_end = tick && ((state == STOP && !HAS_GAP) ||
                                (state == GAP && gap_cnt == 4'd0));
    assign empty = count == '0;
    assign pop   = !empty && (state == IDLE || frame_end);
    assign write = strobe && (!full || pop);

`ifdef IKBD_SERIAL_TX_FIFO_EN
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;

    assign head = mem[rd_ptr];
    assign full = count == CW'(DEPTH);

    always_ff @(posedge clk) begin
        if (write) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (write) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (write && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !write) begin
                count <= count - 1'b1;
            end
        end
    end
`else
    logic [7:0] hold;
    logic       hold_valid;

    assign head  = hold;
    assign full  = hold_valid;
    assign count = {{DEPTH_LOG2{1'b0}}, hold_valid};

    always_ff @(posedge clk) begin
        if (reset) begin
            hold       <= 8'd0;
            hold_valid <= 1'b0;
        end else if (write) begin
            hold       <= din;
            hold_valid <= 1'b1;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (strobe && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            timer   <= 12'd0;
            shift   <= 8'd0;
            idx     <= 3'd0;
            gap_cnt <= 4'd0;
            fast_q  <= 1'b0;
        end else if (pop) begin
            state  <= START;
            tx     <= 1'b0;
            busy   <= 1'b1;
            shift  <= head;
            idx    <= 3'd0;
            fast_q <= fast;
            timer  <= fast ? RELOAD_FAST : RELOAD_SLOW;
        end else if (state != IDLE) begin
            if (!tick) begin
                timer <= timer - 12'd1;
            end else begin
                timer <= fast_q ? RELOAD_FAST : RELOAD_SLOW;
                unique case (state)
                    START: begin
                        state <= DATA;
                        tx    <= shift[0];
                        shift <= shift >> 1;
                    end
                    DATA: begin
                        if (idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            tx    <= shift[0];
                            shift <= shift >> 1;
                            idx   <= idx + 3'd1;
                        end
                    end
                    STOP: begin
                        if (HAS_GAP) begin
                            state   <= GAP;
                            gap_cnt <= GAP_LAST;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    GAP: begin
                        if (gap_cnt == 4'd0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt - 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ikbd_serial_tx.sv
// Self-checking bench for ikbd_serial_tx: frame-level reference model plus
// vector table and directed corner sequences, using short divisors.
module tb_ikbd_serial_tx;

    localparam int DS  = 40;
    localparam int DF  = 12;
    localparam int GB  = 1;
    localparam int DL2 = 4;
    localparam int NB  = 10 + GB;
`ifdef IKBD_SERIAL_TX_FIFO_EN
    localparam int DEPTH = 16;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] din = 8'd0;
    logic       strobe = 1'b0;
    logic       fast = 1'b0;
    logic       tx;
    logic       busy;
    logic       full;
    logic [DL2:0] count;
    logic       overflow;

    always #5 clk = ~clk;

    ikbd_serial_tx #(
        .DIV_SLOW(DS), .DIV_FAST(DF), .DEPTH_LOG2(DL2), .GAP_BITS(GB)
    ) dut (
        .clk(clk), .reset(reset), .din(din), .strobe(strobe), .fast(fast),
        .tx(tx), .busy(busy), .full(full), .count(count), .overflow(overflow)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: byte queue plus current frame position in clocks.
    logic [7:0] q[$];
    bit         m_act = 0;
    int         m_pos = 0;
    int         m_div = DS;
    logic [7:0] m_byte = 8'd0;
    bit         m_ovf = 0;

    function automatic logic m_tx();
        int b;
        if (!m_act) return 1'b1;
        b = m_pos / m_div;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_byte[b-1];
        return 1'b1;
    endfunction

    task automatic model_step();
        bit ending, popn, acc;
        if (reset) begin
            q.delete();
            m_act = 0;
            m_pos = 0;
            m_ovf = 0;
        end else begin
            ending = m_act && (m_pos == NB * m_div - 1);
            popn = (q.size() > 0) && (!m_act || ending);
            acc = strobe && ((q.size() < DEPTH) || popn);
            if (strobe && !acc) m_ovf = 1;
            if (popn) begin
                m_byte = q.pop_front();
                m_div = fast ? DF : DS;
                m_pos = 0;
                m_act = 1;
            end else if (ending) begin
                m_act = 0;
            end else if (m_act) begin
                m_pos++;
            end
            if (acc) q.push_back(din);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en)
            chk("cycle", {tx, busy, full, overflow, count},
                {m_tx(), m_act, q.size() == DEPTH, m_ovf, 5'(q.size())});
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] d;
        logic       f;
        logic [9:0] bits;
    } vec_t;

    vec_t tbl[4];

    task automatic pulse(input logic [7:0] d, input logic f);
        din = d;
        fast = f;
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m_act || q.size() != 0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", n < 20000, 1);
    endtask

    initial begin
        int n, t0, t1, t2, dv;
        logic [7:0] bb[3];
        int expc[3];

        tbl[0] = '{8'hA5, 1'b0, 10'b1101001010};
        tbl[1] = '{8'h00, 1'b1, 10'b1000000000};
        tbl[2] = '{8'hFF, 1'b1, 10'b1111111110};
        tbl[3] = '{8'h3C, 1'b0, 10'b1001111000};

        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        reset = 1'b0;
        chk_en = 1;

        for (int k = 0; k < 4; k++) begin
            dv = tbl[k].f ? DF : DS;
            wait_idle();
            pulse(tbl[k].d, tbl[k].f);
            chk("t_count", count, 1);
            chk("t_tx_pre", tx, 1);
            @(negedge clk);
            chk("t_tx_fall", tx, 0);
            repeat (dv / 2) @(negedge clk);
            for (int i = 0; i < 10; i++) begin
                if (i > 0) repeat (dv) @(negedge clk);
                chk($sformatf("t%0d_bit%0d", k, i), tx, tbl[k].bits[i]);
            end
            repeat (dv / 2 + GB * dv - 1) @(negedge clk);
            chk("t_busy_end", busy, 1);
            @(negedge clk);
            chk("t_busy_drop", busy, 0);
        end

        wait_idle();
        bb[0] = 8'h00; bb[1] = 8'hFF; bb[2] = 8'h3C;
        expc[0] = 1; expc[1] = 1; expc[2] = (DEPTH >= 2) ? 2 : 1;
        for (int k = 0; k < 3; k++) begin
            din = bb[k];
            fast = 1'b1;
            strobe = 1'b1;
            @(negedge clk);
            chk($sformatf("b_count%0d", k), count, expc[k]);
        end
        strobe = 1'b0;
        n = 0;
        while (busy && n < 20000) begin
            n++;
            @(negedge clk);
        end
        chk("b_span", n, ((DEPTH >= 2) ? 3 : 2) * NB * DF - 1);

        for (int c = 0; c < 4000; c++) begin
            strobe = ($urandom_range(0, 39) == 0);
            din = 8'($urandom);
            if ($urandom_range(0, 149) == 0) fast = ~fast;
            @(negedge clk);
        end
        strobe = 1'b0;

        wait_idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        fast = 1'b1;
        for (int k = 0; k <= DEPTH; k++) begin
            din = 8'(k * 7 + 1);
            strobe = 1'b1;
            @(negedge clk);
        end
        strobe = 1'b0;
        chk("f_full", full, 1);
        chk("f_count", count, DEPTH);
        chk("f_ovf", overflow, 0);
        n = 0;
        while (!(m_act && m_pos == NB * m_div - 1) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("pop_wait", n < 20000, 1);
        pulse(8'hE7, 1'b1);
        chk("pf_count", count, DEPTH);
        chk("pf_ovf", overflow, 0);
        chk("pf_full", full, 1);
        pulse(8'h18, 1'b1);
        chk("ov_ovf", overflow, 1);
        chk("ov_count", count, DEPTH);

        wait_idle();
        pulse(8'hFF, 1'b0);
        n = 0;
        while (tx !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        t0 = cyc;
        repeat (5 * DS) @(negedge clk);
        pulse(8'hFF, 1'b1);
        n = 0;
        while (tx !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        t1 = cyc;
        chk("tg_slow", t1 - t0, NB * DS);
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        t2 = cyc;
        chk("tg_fast", t2 - t1, NB * DF);

        wait_idle();
        pulse(8'h5A, 1'b1);
        pulse(8'h33, 1'b1);
        n = 0;
        while (!(m_act && m_pos == 4 * DF + 3) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("rs_wait", n < 2000, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rs_tx", tx, 1);
        chk("rs_busy", busy, 0);
        chk("rs_count", count, 0);
        chk("rs_ovf", overflow, 0);
        n = 0;
        repeat (3 * NB * DF) begin
            @(negedge clk);
            if (tx !== 1'b1) n++;
        end
        chk("rs_quiet", n, 0);
        chk("rs_busy_end", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
